// File: rtl/sa_blkbox_pkg.sv
// Shared constants for the sa_blkbox skid buffer: state encoding and default payload width.
// The state register doubles as the occupancy count, so the encodings are the counts 0..2.
package sa_blkbox_pkg;

  localparam int unsigned SA_BLKBOX_DW = 32;

  localparam logic [1:0] SKID_EMPTY = 2'd0;
  localparam logic [1:0] SKID_ONE   = 2'd1;
  localparam logic [1:0] SKID_FULL  = 2'd2;

  // Output flags are registered from the next state, so these decode the value being loaded.
  function automatic logic skid_has_data(input logic [1:0] state);
    return state != SKID_EMPTY;
  endfunction

  function automatic logic skid_has_room(input logic [1:0] state);
    return state != SKID_FULL;
  endfunction

endpackage

// File: rtl/sa_blkbox_pd_reg.sv
// Enabled payload register with asynchronous reset to a fixed payload value.
// It loads only when enabled, so X on an unaccepted input never reaches the stored payload.
module sa_blkbox_pd_reg
  import sa_blkbox_pkg::*;
#(
  parameter int unsigned   DW       = SA_BLKBOX_DW,
  parameter logic [DW-1:0] RESET_PD = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  // NOTE: sequential state uses non-blocking (<=) so all flops sample pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_PD;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sa_blkbox_skid_buffer.sv
// Two-entry registered valid/ready stage: main register drives out_pd, skid register catches
// the beat that arrives while downstream stalls. Every output is driven straight from a flop.
module sa_blkbox_skid_buffer
  import sa_blkbox_pkg::*;
#(
  parameter int unsigned   DW       = SA_BLKBOX_DW,
  parameter logic [DW-1:0] RESET_PD = '0
) (
  input  logic          sa_core_clk,
  input  logic          sa_core_rstn,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_pd,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_pd,
  output logic [1:0]    occ
);

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic          out_vld_q;
  logic          in_rdy_q;
  logic          in_acc;
  logic          out_acc;
  logic          main_en;
  logic          skid_en;
  logic          main_from_skid;
  logic [DW-1:0] main_d;
  logic [DW-1:0] skid_pd;

  assign in_acc  = in_vld  & in_rdy_q;
  assign out_acc = out_vld_q & out_rdy;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (in_acc) begin
          state_d = SKID_ONE;
          main_en = 1'b1;
        end
      end
      SKID_ONE: begin
        if (in_acc && out_acc) begin
          main_en = 1'b1;
        end else if (in_acc) begin
          state_d = SKID_FULL;
          skid_en = 1'b1;
        end else if (out_acc) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        // in_rdy is low here, so only the drain into main can happen; the skid beat is never bypassed.
        if (out_acc) begin
          state_d        = SKID_ONE;
          main_en        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  assign main_d = main_from_skid ? skid_pd : in_pd;

  always_ff @(posedge sa_core_clk or negedge sa_core_rstn) begin
    if (!sa_core_rstn) begin
      state_q   <= SKID_EMPTY;
      out_vld_q <= 1'b0;
      in_rdy_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      out_vld_q <= skid_has_data(state_d);
      in_rdy_q  <= skid_has_room(state_d);
    end
  end

  sa_blkbox_pd_reg #(.DW(DW), .RESET_PD(RESET_PD)) u_main_reg (
    .clk   (sa_core_clk),
    .rst_n (sa_core_rstn),
    .en    (main_en),
    .d     (main_d),
    .q     (out_pd)
  );

  sa_blkbox_pd_reg #(.DW(DW), .RESET_PD(RESET_PD)) u_skid_reg (
    .clk   (sa_core_clk),
    .rst_n (sa_core_rstn),
    .en    (skid_en),
    .d     (in_pd),
    .q     (skid_pd)
  );

  assign out_vld = out_vld_q;
  assign in_rdy  = in_rdy_q;
  assign occ     = state_q;

endmodule

// File: tb/tb_sa_blkbox_skid_buffer.sv
// Self-checking bench for sa_blkbox_skid_buffer: a two-deep queue model checked every cycle,
// plus directed vectors with literal expectations.
module tb_sa_blkbox_skid_buffer;

  localparam int unsigned DW = 32;

  logic          sa_core_clk = 1'b0;
  logic          sa_core_rstn = 1'b0;
  logic          in_vld = 1'b0;
  logic          in_rdy;
  logic [DW-1:0] in_pd = '0;
  logic          out_vld;
  logic          out_rdy = 1'b0;
  logic [DW-1:0] out_pd;
  logic [1:0]    occ;

  int n_cmp = 0;
  int n_err = 0;

  sa_blkbox_skid_buffer #(.DW(DW), .RESET_PD('0)) dut (
    .sa_core_clk  (sa_core_clk),
    .sa_core_rstn (sa_core_rstn),
    .in_vld       (in_vld),
    .in_rdy       (in_rdy),
    .in_pd        (in_pd),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .out_pd       (out_pd),
    .occ          (occ)
  );

  always #5 sa_core_clk = ~sa_core_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of at most two beats; out_pd shows the head, or the last beat popped when empty.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_last = '0;
  bit            m_in_acc;
  bit            m_out_acc;

  always @(posedge sa_core_clk or negedge sa_core_rstn) begin
    if (!sa_core_rstn) begin
      mq.delete();
      m_last = '0;
    end else begin
      m_in_acc  = in_vld && (mq.size() < 2);
      m_out_acc = out_rdy && (mq.size() > 0);
      if (m_out_acc) m_last = mq.pop_front();
      if (m_in_acc) mq.push_back(in_pd);
    end
  end

  always @(negedge sa_core_clk) begin
    check("m_out_vld", 64'(out_vld), 64'(mq.size() != 0));
    check("m_in_rdy",  64'(in_rdy),  64'(mq.size() < 2));
    check("m_occ",     64'(occ),     64'(mq.size()));
    check("m_out_pd",  64'(out_pd),  64'((mq.size() != 0) ? mq[0] : m_last));
  end

  task automatic drive(input logic v, input logic [DW-1:0] pd, input logic r);
    in_vld  = v;
    in_pd   = pd;
    out_rdy = r;
  endtask

  task automatic step();
    @(posedge sa_core_clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input logic r,
                            input logic [1:0] o, input logic [DW-1:0] pd);
    check({name, "_out_vld"}, 64'(out_vld), 64'(v));
    check({name, "_in_rdy"},  64'(in_rdy),  64'(r));
    check({name, "_occ"},     64'(occ),     64'(o));
    check({name, "_out_pd"},  64'(out_pd),  64'(pd));
  endtask

  initial begin
    // Reset held for three cycles, then released just after an edge.
    drive(1'b1, 32'hDEAD_BEEF, 1'b1);
    repeat (3) step();
    expect_out("rst_hold", 1'b0, 1'b1, 2'd0, 32'h0);
    drive(1'b0, 32'h0, 1'b0);
    sa_core_rstn = 1'b1;
    step();
    expect_out("rst_rel", 1'b0, 1'b1, 2'd0, 32'h0);

    // Streaming with downstream always ready: each beat appears one cycle later, no bubbles.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, DW'(i), 1'b1);
      step();
      expect_out("stream", 1'b1, 1'b1, 2'd1, DW'(i));
    end
    drive(1'b0, 32'h5555_5555, 1'b1);
    step();
    expect_out("stream_end", 1'b0, 1'b1, 2'd0, 32'h9);

    // Backpressure fill: second beat lands in skid, third is refused.
    drive(1'b1, 32'hA1, 1'b0);
    step();
    expect_out("bp_a1", 1'b1, 1'b1, 2'd1, 32'hA1);
    drive(1'b1, 32'hA2, 1'b0);
    step();
    expect_out("bp_a2", 1'b1, 1'b0, 2'd2, 32'hA1);
    drive(1'b1, 32'hA3, 1'b0);
    step();
    expect_out("bp_a3", 1'b1, 1'b0, 2'd2, 32'hA1);

    // Drain in order while 0xA3 stays offered until it is taken.
    drive(1'b1, 32'hA3, 1'b1);
    step();
    expect_out("drain_a2", 1'b1, 1'b1, 2'd1, 32'hA2);
    step();
    expect_out("drain_a3", 1'b1, 1'b1, 2'd1, 32'hA3);
    drive(1'b0, 32'h0, 1'b1);
    step();
    expect_out("drain_end", 1'b0, 1'b1, 2'd0, 32'hA3);

    // Async reset between edges while full: outputs clear without waiting for a clock.
    drive(1'b1, 32'hB1, 1'b0);
    step();
    drive(1'b1, 32'hB2, 1'b0);
    step();
    expect_out("ar_full", 1'b1, 1'b0, 2'd2, 32'hB1);
    drive(1'b0, 32'h0, 1'b0);
    #2;
    sa_core_rstn = 1'b0;
    #1;
    expect_out("ar_now", 1'b0, 1'b1, 2'd0, 32'h0);
    step();
    sa_core_rstn = 1'b1;
    drive(1'b1, 32'hC1, 1'b1);
    step();
    expect_out("ar_first", 1'b1, 1'b1, 2'd1, 32'hC1);
    drive(1'b0, 32'h0, 1'b1);
    step();
    expect_out("ar_empty", 1'b0, 1'b1, 2'd0, 32'hC1);

    // Random stress: the per-cycle model compare does the checking.
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
      step();
    end
    drive(1'b0, 32'h0, 1'b1);
    repeat (3) step();
    expect_out("final_empty", 1'b0, 1'b1, 2'd0, out_vld ? 32'h0 : out_pd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
